// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU: ALUOp/funct encodings, op codes, FSM states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_SLTU    = 4'b0010;
    localparam logic [3:0] OP_AND     = 4'b0011;
    localparam logic [3:0] OP_OR      = 4'b0100;
    localparam logic [3:0] OP_SLT     = 4'b0101;
    localparam logic [3:0] OP_NOR     = 4'b0110;
    localparam logic [3:0] OP_XOR     = 4'b0111;
    localparam logic [3:0] OP_MULTU   = 4'b1000;
    localparam logic [3:0] OP_DIVU    = 4'b1001;
    localparam logic [3:0] OP_SLLV    = 4'b1010;
    localparam logic [3:0] OP_SRLV    = 4'b1011;
    localparam logic [3:0] OP_SRAV    = 4'b1100;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// done and the *_nxt outputs expose the final iteration combinationally so the caller registers it.
module alu_iter_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] lo_nxt,
    output logic [DATA_W-1:0] hi_nxt
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic              div_q, div_d;
    logic [DATA_W:0]   sum, shl, diff;

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dvs_d = dvs_q;
        div_d = div_q;
        sum   = {1'b0, hi_q} + {1'b0, dvs_q};
        shl   = {hi_q, lo_q[DATA_W-1]};
        diff  = shl - {1'b0, dvs_q};
        if (start) begin
            cnt_d = CNT_W'(DATA_W);
            hi_d  = '0;
            lo_d  = op_a;
            dvs_d = op_b;
            div_d = is_div;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
                if (shl >= {1'b0, dvs_q}) begin
                    hi_d = diff[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = shl[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {sum, lo_q[DATA_W-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dvs_q <= dvs_d;
            div_q <= div_d;
        end
    end

    assign done   = (cnt_q == CNT_W'(1));
    assign lo_nxt = lo_d;
    assign hi_nxt = hi_d;

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decode ALUOp/funct, execute, valid/ready handshake on both sides.
// Define ALU_SHIFT_OPS_EN to add SLLV/SRLV/SRAV; otherwise those functs decode as illegal.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              zero,
    output logic [3:0]        op_code,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic              zero_q, zero_d, illegal_q, illegal_d, md_div_q, md_div_d;
    logic [3:0]        op_code_q, op_code_d, dec_op;
    logic [DATA_W-1:0] alu_res, md_lo, md_hi;
    logic              take, md_start, md_done;

    always_comb begin
        dec_op = OP_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: dec_op = OP_ADD;
            ALUOP_SUB: dec_op = OP_SUB;
            ALUOP_ORI: dec_op = OP_OR;
            default: begin
                case (func)
                    F_ADD, F_ADDU: dec_op = OP_ADD;
                    F_SUB, F_SUBU: dec_op = OP_SUB;
                    F_AND:         dec_op = OP_AND;
                    F_OR:          dec_op = OP_OR;
                    F_XOR:         dec_op = OP_XOR;
                    F_NOR:         dec_op = OP_NOR;
                    F_SLT:         dec_op = OP_SLT;
                    F_SLTU:        dec_op = OP_SLTU;
                    F_MULTU:       dec_op = OP_MULTU;
                    F_DIVU:        dec_op = OP_DIVU;
`ifdef ALU_SHIFT_OPS_EN
                    F_SLLV:        dec_op = OP_SLLV;
                    F_SRLV:        dec_op = OP_SRLV;
                    F_SRAV:        dec_op = OP_SRAV;
`endif
                    default:       dec_op = OP_ILLEGAL;
                endcase
            end
        endcase
    end

`ifdef ALU_SHIFT_OPS_EN
    localparam int SH_W = $clog2(DATA_W);
    logic [SH_W-1:0] shamt;
    assign shamt = src_a[SH_W-1:0];
`endif

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res[0] = ($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_res[0] = (src_a < src_b);
`ifdef ALU_SHIFT_OPS_EN
            OP_SLLV: alu_res = src_b << shamt;
            OP_SRLV: alu_res = src_b >> shamt;
            OP_SRAV: alu_res = $signed(src_b) >>> shamt;
`endif
            default: alu_res = '0;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        op_code_d   = op_code_q;
        illegal_d   = illegal_q;
        md_div_d    = md_div_q;
        md_start    = 1'b0;
        case (state_q)
            ST_CALC: begin
                if (md_done) begin
                    state_d     = ST_DONE;
                    result_d    = md_lo;
                    result_hi_d = md_hi;
                    zero_d      = (md_lo == '0);
                    op_code_d   = md_div_q ? OP_DIVU : OP_MULTU;
                    illegal_d   = 1'b0;
                end
            end
            default: begin
                if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
                if (take) begin
                    if (dec_op == OP_MULTU || dec_op == OP_DIVU) begin
                        md_start = 1'b1;
                        md_div_d = (dec_op == OP_DIVU);
                        state_d  = ST_CALC;
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        op_code_d   = dec_op;
                        illegal_d   = (dec_op == OP_ILLEGAL);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            op_code_q   <= OP_ADD;
            illegal_q   <= 1'b0;
            md_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            op_code_q   <= op_code_d;
            illegal_q   <= illegal_d;
            md_div_q    <= md_div_d;
        end
    end

    alu_iter_muldiv #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (dec_op == OP_DIVU),
        .op_a   (src_a),
        .op_b   (src_b),
        .done   (md_done),
        .lo_nxt (md_lo),
        .hi_nxt (md_hi)
    );

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign op_code   = op_code_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: stimulus pushes expectations, a negedge monitor pops on handshake.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  func = 6'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result, result_hi;
    logic        zero, illegal;
    logic [3:0]  op_code;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func(func), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .zero(zero), .op_code(op_code), .illegal(illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                                input logic [3:0] op, input logic ill);
        exp_t e;
        e.res = r; e.hi = h; e.z = (r == 32'd0); e.op = op; e.ill = ill;
        return e;
    endfunction

    // Monitor: compare each accepted output against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {32'd0, result}, {32'd0, e.res});
                check("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
                check("zero", {63'd0, zero}, {63'd0, e.z});
                check("op_code", {60'd0, op_code}, {60'd0, e.op});
                check("illegal", {63'd0, illegal}, {63'd0, e.ill});
            end
        end
    end

    // Called at posedge+1; returns right after the transfer edge (+1).
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e, input bit push);
        int guard = 0;
        in_valid = 1'b1; alu_op = op; func = fn; src_a = a; src_b = b;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 64'd0, 64'd1);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = 32'hA5A5A5A5;
        src_b = 32'h5A5A5A5A;
    endtask

    // Counts cycles from the transfer until out_valid; ends at a negedge.
    task automatic wait_valid(input bit iter, output int l);
        l = 1;
        @(negedge clk);
        if (iter) check("in_ready_calc", {63'd0, in_ready}, 64'd0);
        while (!out_valid && l < 100) begin
            @(posedge clk);
            @(negedge clk);
            l++;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input int exp_lat);
        int l;
        issue(op, fn, a, b, e, 1'b1);
        wait_valid(exp_lat > 1, l);
        check("latency", 64'(l), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_result_hi", {32'd0, result_hi}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_op_code", {60'd0, op_code}, 64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(2'b10, 6'b100010, 32'd5, 32'd7, mk(32'hFFFFFFFE, 0, 4'b0001, 0), 1);
        send(2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2, mk(32'hFFFFFFFE, 32'd1, 4'b1000, 0), 33);
        send(2'b10, 6'b011011, 32'd100, 32'd0, mk(32'hFFFFFFFF, 32'd100, 4'b1001, 0), 33);
        send(2'b10, 6'b011011, 32'd100, 32'd7, mk(32'd14, 32'd2, 4'b1001, 0), 33);
        send(2'b10, 6'b011001, 32'h00010000, 32'h00010000, mk(32'd0, 32'd1, 4'b1000, 0), 33);
        send(2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1, mk(32'd0, 0, 4'b0000, 0), 1);
        send(2'b01, 6'b000000, 32'd3, 32'd10, mk(32'hFFFFFFF9, 0, 4'b0001, 0), 1);
        send(2'b11, 6'b000000, 32'h000000F0, 32'h0000000F, mk(32'h000000FF, 0, 4'b0100, 0), 1);
        send(2'b10, 6'b100001, 32'h7FFFFFFF, 32'd1, mk(32'h80000000, 0, 4'b0000, 0), 1);
        send(2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1, mk(32'd0, 0, 4'b0010, 0), 1);
        send(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 0, 4'b0011, 0), 1);
        send(2'b10, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h0FF00FF0, 0, 4'b0111, 0), 1);
        send(2'b10, 6'b100111, 32'd0, 32'd0, mk(32'hFFFFFFFF, 0, 4'b0110, 0), 1);
        send(2'b10, 6'b111111, 32'd9, 32'd9, mk(32'd0, 0, 4'b1111, 1), 1);
`ifdef ALU_SHIFT_OPS_EN
        send(2'b10, 6'b000111, 32'd4, 32'h80000000, mk(32'hF8000000, 0, 4'b1100, 0), 1);
        send(2'b10, 6'b000100, 32'd36, 32'h00000003, mk(32'h00000030, 0, 4'b1010, 0), 1);
`else
        send(2'b10, 6'b000111, 32'd4, 32'h80000000, mk(32'd0, 0, 4'b1111, 1), 1);
        send(2'b10, 6'b000100, 32'd36, 32'h00000003, mk(32'd0, 0, 4'b1111, 1), 1);
`endif

        // Hold with out_ready low, then release together with a new request.
        out_ready = 1'b0;
        issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, mk(32'd1, 0, 4'b0101, 0), 1'b1);
        wait_valid(1'b0, lat);
        check("slt_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", {32'd0, result}, 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, 6'b000000, 32'd2, 32'd3, mk(32'd5, 0, 4'b0000, 0), 1);

        // Reset in the middle of a divide; the aborted result must never appear.
        issue(2'b10, 6'b011011, 32'd100, 32'd7, mk(32'd0, 0, 4'b0000, 0), 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_result_hi", {32'd0, result_hi}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; alu_op = 2'b00; src_a = 32'd7; src_b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_xfer_in_reset", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        send(2'b00, 6'b000000, 32'd1, 32'd1, mk(32'd2, 0, 4'b0000, 0), 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
